// File: rtl/rle_word_packer_pkg.sv
// rle_pkg: default sizing for the zero-run-length word packer and the
// slot-width helper shared by the top level and the lane scanner.
//   RLE_LANES   input lanes per cycle
//   RLE_DATA_W  bits per element
//   RLE_RUN_W   zero-run field width
//   RLE_GROUPS  (run,value) groups per output word
package rle_pkg;
    localparam int RLE_LANES  = 16;
    localparam int RLE_DATA_W = 8;
    localparam int RLE_RUN_W  = 4;
    localparam int RLE_GROUPS = 5;

    // One packed group: run in the low bits, value above it.
    function automatic int slot_w(input int run_w, input int data_w);
        return run_w + data_w;
    endfunction
endpackage

// File: rtl/rle_lane_scan.sv
// rle_lane_scan: combinational in-order prefix scan over the offered lanes.
// Starting from the carried run and closed-group count it decides, per lane,
// whether the lane is taken, whether it closes a group, which group index it
// closes and the run that group carries. Also returns the state after the
// last taken lane and the number of lanes taken.
//   i_en      0 freezes the scan (nothing taken) while the output is stalled
//   i_data    lane elements, lane 0 oldest
//   i_num     valid lanes
//   i_run     carried zero run
//   i_grp     groups already closed in the word being built
//   o_take/o_close/o_gidx/o_run   per-lane results
//   o_taken, o_run_next, o_grp_next  totals after the scan
module rle_lane_scan
    import rle_pkg::*;
#(
    parameter int LANES  = RLE_LANES,
    parameter int DATA_W = RLE_DATA_W,
    parameter int RUN_W  = RLE_RUN_W,
    parameter int GROUPS = RLE_GROUPS,
    parameter int NUM_W  = $clog2(LANES + 1),
    parameter int GRP_W  = $clog2(GROUPS + 1)
) (
    input  logic                           i_en,
    input  logic [LANES-1:0][DATA_W-1:0]   i_data,
    input  logic [NUM_W-1:0]               i_num,
    input  logic [RUN_W-1:0]               i_run,
    input  logic [GRP_W-1:0]               i_grp,
    output logic [LANES-1:0]               o_take,
    output logic [LANES-1:0]               o_close,
    output logic [LANES-1:0][GRP_W-1:0]    o_gidx,
    output logic [LANES-1:0][RUN_W-1:0]    o_run,
    output logic [NUM_W-1:0]               o_taken,
    output logic [RUN_W-1:0]               o_run_next,
    output logic [GRP_W-1:0]               o_grp_next
);
    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    logic [RUN_W-1:0] w_run;
    logic [GRP_W-1:0] w_grp;
    logic [NUM_W-1:0] w_cnt;
    logic             w_go;

    always_comb begin
        w_run = i_run;
        w_grp = i_grp;
        w_cnt = '0;
        w_go  = i_en;
        for (int i = 0; i < LANES; i++) begin
            o_take[i]  = 1'b0;
            o_close[i] = 1'b0;
            o_gidx[i]  = w_grp;
            o_run[i]   = '0;
            // Once a lane is refused, every later lane is refused too, so a
            // full word stops consumption even for zero lanes.
            if (w_go && (NUM_W'(i) < i_num) && (w_grp < GRP_W'(GROUPS))) begin
                o_take[i] = 1'b1;
                w_cnt     = w_cnt + NUM_W'(1);
                if ((i_data[i] != '0) || (w_run == RUN_MAX)) begin
                    // A saturated run closes on a zero, emitted as value 0.
                    o_close[i] = 1'b1;
                    o_run[i]   = w_run;
                    w_grp      = w_grp + GRP_W'(1);
                    w_run      = '0;
                end else begin
                    w_run = w_run + RUN_W'(1);
                end
            end else begin
                w_go = 1'b0;
            end
        end
        o_taken    = w_cnt;
        o_run_next = w_run;
        o_grp_next = w_grp;
    end
endmodule

// File: rtl/rle_word_packer.sv
// rle_word_packer: zero-run-length packer. Encodes up to LANES elements per
// cycle as (run,value) groups and packs GROUPS groups per word; full or
// flushed words leave through a one-deep valid/ready output register.
//   clk, rst_n            clock, synchronous active-low reset
//   in_data/in_num/in_last  offered lanes, valid count, frame end
//   in_taken              lanes consumed this cycle (combinational)
//   out_valid/out_ready   output handshake
//   out_data              packed groups, group k at [k*SLOT_W +: SLOT_W]
//   out_groups            groups used in out_data
//   out_tail_run          last used group is an unterminated run
//   out_last              word closes the frame
module rle_word_packer
    import rle_pkg::*;
#(
    parameter int LANES  = RLE_LANES,
    parameter int DATA_W = RLE_DATA_W,
    parameter int RUN_W  = RLE_RUN_W,
    parameter int GROUPS = RLE_GROUPS,
    parameter int SLOT_W = slot_w(RUN_W, DATA_W),
    parameter int OUT_W  = GROUPS * SLOT_W,
    parameter int NUM_W  = $clog2(LANES + 1),
    parameter int GRP_W  = $clog2(GROUPS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LANES-1:0][DATA_W-1:0]  in_data,
    input  logic [NUM_W-1:0]              in_num,
    input  logic                          in_last,
    output logic [NUM_W-1:0]              in_taken,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic [GRP_W-1:0]              out_groups,
    output logic                          out_tail_run,
    output logic                          out_last
);
    logic [RUN_W-1:0]  r_run;
    logic [GRP_W-1:0]  r_grp;
    logic [OUT_W-1:0]  r_word;
    logic              r_valid;
    logic [OUT_W-1:0]  r_out_data;
    logic [GRP_W-1:0]  r_out_groups;
    logic              r_out_tail;
    logic              r_out_last;

    logic                         w_stall;
    logic [LANES-1:0]             w_take;
    logic [LANES-1:0]             w_close_l;
    logic [LANES-1:0][GRP_W-1:0]  w_gidx;
    logic [LANES-1:0][RUN_W-1:0]  w_run_l;
    logic [NUM_W-1:0]             w_taken;
    logic [RUN_W-1:0]             w_run_next;
    logic [GRP_W-1:0]             w_grp_next;
    logic                         w_full;
    logic                         w_flush;
    logic                         w_close;
    logic                         w_tail;
    logic                         w_carry;
    logic [OUT_W-1:0]             w_word_next;

    // A held word blocks everything; accepting it frees the slot this cycle.
    assign w_stall = r_valid && !out_ready;

    rle_lane_scan #(
        .LANES(LANES), .DATA_W(DATA_W), .RUN_W(RUN_W), .GROUPS(GROUPS),
        .NUM_W(NUM_W), .GRP_W(GRP_W)
    ) u_scan (
        .i_en       (!w_stall),
        .i_data     (in_data),
        .i_num      (in_num),
        .i_run      (r_run),
        .i_grp      (r_grp),
        .o_take     (w_take),
        .o_close    (w_close_l),
        .o_gidx     (w_gidx),
        .o_run      (w_run_l),
        .o_taken    (w_taken),
        .o_run_next (w_run_next),
        .o_grp_next (w_grp_next)
    );

    assign in_taken = w_taken;
    assign w_full   = (w_grp_next == GRP_W'(GROUPS));
    assign w_flush  = !w_stall && in_last && (w_taken == in_num);
    assign w_close  = !w_stall && (w_full || w_flush);
    // An open run at frame end takes one more group when there is room;
    // otherwise it rides into the next word and the frame is not yet over.
    assign w_tail   = w_flush && !w_full && (w_run_next != '0);
    assign w_carry  = w_full && (w_run_next != '0);

    // Per-group mux: at most one taken lane closes any given group index.
    always_comb begin
        w_word_next = r_word;
        for (int k = 0; k < GROUPS; k++) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_take[i] && w_close_l[i] && (w_gidx[i] == GRP_W'(k)))
                    w_word_next[k*SLOT_W +: SLOT_W] = {in_data[i], w_run_l[i]};
            end
            if (w_tail && (w_grp_next == GRP_W'(k)))
                w_word_next[k*SLOT_W +: SLOT_W] = {{DATA_W{1'b0}}, w_run_next};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run        <= '0;
            r_grp        <= '0;
            r_word       <= '0;
            r_valid      <= 1'b0;
            r_out_data   <= '0;
            r_out_groups <= '0;
            r_out_tail   <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            if (w_close) begin
                r_word       <= '0;
                r_grp        <= '0;
                r_run        <= w_carry ? w_run_next : '0;
                r_valid      <= 1'b1;
                r_out_data   <= w_word_next;
                r_out_groups <= w_grp_next + GRP_W'(w_tail);
                r_out_tail   <= w_tail;
                r_out_last   <= w_flush && !w_carry;
            end else begin
                if (!w_stall) begin
                    r_word <= w_word_next;
                    r_grp  <= w_grp_next;
                    r_run  <= w_run_next;
                end
                if (r_valid && out_ready)
                    r_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_data     = r_out_data;
    assign out_groups   = r_out_groups;
    assign out_tail_run = r_out_tail;
    assign out_last     = r_out_last;
endmodule

// File: tb/tb_rle_word_packer.sv
module tb_rle_word_packer;
    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0][7:0]  in_data;
    logic [4:0]        in_num;
    logic              in_last;
    logic [4:0]        in_taken;
    logic              out_valid;
    logic              out_ready;
    logic [59:0]       out_data;
    logic [2:0]        out_groups;
    logic              out_tail_run;
    logic              out_last;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rle_word_packer dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_num(in_num), .in_last(in_last), .in_taken(in_taken),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_groups(out_groups), .out_tail_run(out_tail_run), .out_last(out_last)
    );

    // Expected encoding of one group at index k.
    function automatic logic [59:0] grp(input int k, input int run, input int val);
        logic [59:0] s;
        s = 60'((val << 4) | run);
        return s << (k * 12);
    endfunction

    function automatic logic [59:0] vals5(input int first);
        logic [59:0] w;
        w = '0;
        for (int k = 0; k < 5; k++) w = w | grp(k, 0, first + k);
        return w;
    endfunction

    // Drive at the falling edge; in_taken is read 1 time unit later.
    task automatic drive(input int n, input logic last);
        @(negedge clk);
        in_num  = 5'(n);
        in_last = last;
        #1;
    endtask

    task automatic seq_lanes(input int first);
        in_data = '0;
        for (int i = 0; i < 16; i++) in_data[i] = 8'(first + i);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_data = '0;
        drive(0, 1'b0);
        after_edge();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1; in_data = '0; in_num = '0; in_last = 1'b0;
        repeat (2) after_edge();
        n_chk++;
        if ({out_valid, out_data, out_groups, out_tail_run, out_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b d=%h g=%0d t=%0b l=%0b want all 0",
                     out_valid, out_data, out_groups, out_tail_run, out_last);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic_flush();
        in_data = '0; in_data[0] = 8'h05; in_data[1] = 8'h00; in_data[2] = 8'h03;
        drive(3, 1'b1);
        n_chk++;
        if (in_taken !== 5'd3) begin n_fail++; $display("FAIL basic_taken: got %0d want 3", in_taken); end
        after_edge();
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== (grp(0,0,5) | grp(1,1,3)) || out_groups !== 3'd2 ||
            out_tail_run !== 1'b0 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_word: got v=%0b d=%h g=%0d t=%0b l=%0b want v=1 d=%h g=2 t=0 l=1",
                     out_valid, out_data, out_groups, out_tail_run, out_last, grp(0,0,5) | grp(1,1,3));
        end
        idle();
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got valid %0b want 0", out_valid); end
    endtask

    task automatic test_run_saturation();
        in_data = '0;
        drive(16, 1'b0);
        n_chk++;
        if (in_taken !== 5'd16) begin n_fail++; $display("FAIL sat_taken: got %0d want 16", in_taken); end
        after_edge();
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_noword: got valid %0b want 0", out_valid); end
        in_data = '0; in_data[1] = 8'h09;
        drive(2, 1'b1);
        n_chk++;
        if (in_taken !== 5'd2) begin n_fail++; $display("FAIL sat_taken2: got %0d want 2", in_taken); end
        after_edge();
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== (grp(0,15,0) | grp(1,1,9)) || out_groups !== 3'd2 ||
            out_tail_run !== 1'b0 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_word: got v=%0b d=%h g=%0d t=%0b l=%0b want d=%h g=2 t=0 l=1",
                     out_valid, out_data, out_groups, out_tail_run, out_last, grp(0,15,0) | grp(1,1,9));
        end
    endtask

    // Back-to-back full words with out_ready high: each loads as the prior leaves.
    task automatic test_word_full_split();
        int firsts[4] = '{1, 6, 11, 16};
        int nums[4]   = '{16, 11, 6, 1};
        for (int s = 0; s < 4; s++) begin
            seq_lanes(firsts[s]);
            drive(nums[s], s >= 2);
            n_chk++;
            if (in_taken !== ((s == 3) ? 5'd1 : 5'd5)) begin
                n_fail++; $display("FAIL split_taken%0d: got %0d want %0d", s, in_taken, (s == 3) ? 1 : 5);
            end
            after_edge();
            if (s < 3) begin
                n_chk++;
                if (out_valid !== 1'b1 || out_data !== vals5(firsts[s]) || out_groups !== 3'd5 ||
                    out_tail_run !== 1'b0 || out_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL split_word%0d: got v=%0b d=%h g=%0d t=%0b l=%0b want d=%h g=5 t=0 l=0",
                             s, out_valid, out_data, out_groups, out_tail_run, out_last, vals5(firsts[s]));
                end
            end else begin
                n_chk++;
                if (out_valid !== 1'b1 || out_data !== grp(0,0,16) || out_groups !== 3'd1 || out_last !== 1'b1) begin
                    n_fail++;
                    $display("FAIL split_last: got v=%0b d=%h g=%0d l=%0b want d=%h g=1 l=1",
                             out_valid, out_data, out_groups, out_last, grp(0,0,16));
                end
            end
        end
        idle();
    endtask

    task automatic test_trailing_zeros();
        in_data = '0; in_data[0] = 8'h04;
        drive(3, 1'b1);
        n_chk++;
        if (in_taken !== 5'd3) begin n_fail++; $display("FAIL tail_taken: got %0d want 3", in_taken); end
        after_edge();
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== (grp(0,0,4) | grp(1,2,0)) || out_groups !== 3'd2 ||
            out_tail_run !== 1'b1 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL tail_word: got v=%0b d=%h g=%0d t=%0b l=%0b want d=%h g=2 t=1 l=1",
                     out_valid, out_data, out_groups, out_tail_run, out_last, grp(0,0,4) | grp(1,2,0));
        end
        idle();
    endtask

    task automatic test_back_pressure();
        in_data = '0; in_data[0] = 8'h07;
        out_ready = 1'b0;
        drive(1, 1'b1);
        after_edge();
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== grp(0,0,7)) begin
            n_fail++; $display("FAIL bp_load: got v=%0b d=%h want v=1 d=%h", out_valid, out_data, grp(0,0,7));
        end
        in_data[0] = 8'h08;
        for (int c = 0; c < 3; c++) begin
            drive(1, 1'b1);
            n_chk++;
            if (in_taken !== 5'd0) begin n_fail++; $display("FAIL bp_taken%0d: got %0d want 0", c, in_taken); end
            after_edge();
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== grp(0,0,7) || out_groups !== 3'd1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%0b d=%h g=%0d want v=1 d=%h g=1",
                         c, out_valid, out_data, out_groups, grp(0,0,7));
            end
        end
        @(negedge clk); out_ready = 1'b1;
        #1;
        n_chk++;
        if (in_taken !== 5'd1) begin n_fail++; $display("FAIL bp_release_taken: got %0d want 1", in_taken); end
        after_edge();
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== grp(0,0,8) || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_no_bubble: got v=%0b d=%h l=%0b want v=1 d=%h l=1", out_valid, out_data, out_last, grp(0,0,8));
        end
        idle();
    endtask

    task automatic test_empty_and_reset();
        in_data = '0;
        drive(0, 1'b1);
        after_edge();
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== '0 || out_groups !== 3'd0 || out_tail_run !== 1'b0 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_word: got v=%0b d=%h g=%0d t=%0b l=%0b want v=1 d=0 g=0 t=0 l=1",
                     out_valid, out_data, out_groups, out_tail_run, out_last);
        end
        in_data = '0; in_data[0] = 8'h01; in_data[1] = 8'h02;
        drive(2, 1'b0);
        after_edge();
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_noword: got valid %0b want 0", out_valid); end
        @(negedge clk); rst_n = 1'b0; in_num = '0; in_last = 1'b0; in_data = '0;
        after_edge();
        n_chk++;
        if ({out_valid, out_data, out_groups, out_tail_run, out_last} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%0b d=%h g=%0d t=%0b l=%0b want all 0",
                     out_valid, out_data, out_groups, out_tail_run, out_last);
        end
        @(negedge clk); rst_n = 1'b1;
        drive(0, 1'b1);
        after_edge();
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== '0 || out_groups !== 3'd0 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_discard: got v=%0b d=%h g=%0d l=%0b want v=1 d=0 g=0 l=1",
                     out_valid, out_data, out_groups, out_last);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_flush();
        test_run_saturation();
        test_word_full_split();
        test_trailing_zeros();
        test_back_pressure();
        test_empty_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
